// File: rtl/uart_pkg.sv
// Shared UART TX definitions: frame constants, FSM state encoding and clog2 helper.
// Optional parity support is selected by UART_TX_PARITY_EN in the scheduler.
package uart_pkg;

  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned DATA_BITS     = 8;
  localparam int unsigned TICK_CNT_W    = 4;
  localparam int unsigned BIT_IDX_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the pointer, with wrap.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_c_o,
  output logic [ID_W-1:0]    gnt_idx_c_o
);

  always_comb begin
    logic            found;
    logic [ID_W-1:0] cand;
    gnt_c_o     = '0;
    gnt_idx_c_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        gnt_c_o[cand] = 1'b1;
        gnt_idx_c_o   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin UART transmit scheduler: grants one requester per frame and serialises its byte.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned ID_W      = clog2(NUM_REQ)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   TICK16,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [8*NUM_REQ-1:0]   DATA,
  output logic [NUM_REQ-1:0]     ACK,
  output logic                   TX,
  output logic                   BUSY,
  output logic [ID_W-1:0]        CUR_ID
);

  uart_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic [ID_W-1:0]        cur_id_q, cur_id_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [TICK_CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic [NUM_REQ-1:0]     gnt_c;
  logic [ID_W-1:0]        gnt_idx_c;
  logic [DATA_BITS-1:0]   bytes_c [NUM_REQ];
  logic [DATA_BITS-1:0]   sel_byte_c;
  logic                   bit_end_c;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i       (REQ),
    .ptr_i       (ptr_q),
    .gnt_c_o     (gnt_c),
    .gnt_idx_c_o (gnt_idx_c)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign bytes_c[g] = DATA[g*DATA_BITS +: DATA_BITS];
  end

  assign sel_byte_c = bytes_c[gnt_idx_c];
  assign bit_end_c  = TICK16 && (tick_cnt_q == TICK_CNT_W'(TICKS_PER_BIT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ack_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      cur_id_q   <= '0;
      ptr_q      <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      cur_id_q   <= cur_id_d;
      ptr_q      <= ptr_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Next-state logic; the tick counter only runs while a frame is in flight
  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    tx_d       = tx_q;
    busy_d     = busy_q;
    cur_id_d   = cur_id_q;
    ptr_d      = ptr_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != ST_IDLE && TICK16) begin
      tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (|REQ) begin
          ack_d      = gnt_c;
          shift_d    = sel_byte_c;
          cur_id_d   = gnt_idx_c;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
          state_d    = ST_START;
          tick_cnt_d = '0;
          bit_idx_d  = '0;
          ptr_d      = (gnt_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + ID_W'(1);
`ifdef UART_TX_PARITY_EN
          parity_d   = ^sel_byte_c;
`endif
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
            tx_d      = parity_q;
`else
            state_d   = ST_STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_c) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end_c) begin
          if (bit_idx_q == BIT_IDX_W'(STOP_BITS - 1)) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            tx_d      = 1'b1;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign ACK    = ack_q;
  assign TX     = tx_q;
  assign BUSY   = busy_q;
  assign CUR_ID = cur_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed vector table, corner sequences and
// randomized traffic checked every cycle against a frame-level reference model.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS       = 10 + PAR + STOP_BITS - 1;
  localparam int FRAME_TICKS = NBITS * 16;

  logic        clk;
  logic        rst;
  logic        tick16;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        tx;
  logic        busy;
  logic [1:0]  cur_id;

  int checks;
  int failures;
  int tick_div;
  int phase;
  bit last_tick;

  // Frame-level reference model state
  bit          m_busy;
  int          m_tick;
  logic        m_bits [12];
  logic [3:0]  m_ack;
  logic        m_tx;
  logic [1:0]  m_id;
  int          m_ptr;

  uart_tx_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .TICK16 (tick16),
    .REQ    (req),
    .DATA   (data),
    .ACK    (ack),
    .TX     (tx),
    .BUSY   (busy),
    .CUR_ID (cur_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_tick = 0;
    m_ack  = '0;
    m_tx   = 1'b1;
    m_id   = '0;
    m_ptr  = 0;
  endtask

  // Advance the model by one clock edge using the inputs that were present at that edge
  task automatic model_step();
    int         g;
    int         c;
    logic [7:0] b;
    if (rst) begin
      model_reset();
      return;
    end
    m_ack = '0;
    if (!m_busy) begin
      if (req != 4'b0000) begin
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
          c = (m_ptr + k) % NUM_REQ;
          if (g < 0 && req[c]) g = c;
        end
        b = data[g*8 +: 8];
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[1+i] = b[i];
        if (PAR == 1) m_bits[9] = ^b;
        for (int s = 0; s < STOP_BITS; s++) m_bits[9+PAR+s] = 1'b1;
        m_ack[g] = 1'b1;
        m_id     = 2'(g);
        m_ptr    = (g + 1) % NUM_REQ;
        m_busy   = 1'b1;
        m_tick   = 0;
        m_tx     = 1'b0;
      end else begin
        m_tx = 1'b1;
      end
    end else if (tick16) begin
      m_tick++;
      if (m_tick == FRAME_TICKS) begin
        m_busy = 1'b0;
        m_tx   = 1'b1;
      end else begin
        m_tx = m_bits[m_tick/16];
      end
    end
  endtask

  task automatic cycle();
    if (tick_div == 0) begin
      tick16 = ($urandom_range(0, 2) == 0);
    end else begin
      tick16 = (phase == 0);
      phase  = (phase + 1) % tick_div;
    end
    last_tick = tick16;
    @(posedge clk);
    model_step();
    #1;
    chk("ack", 32'(ack), 32'(m_ack));
    chk("tx", 32'(tx), 32'(m_tx));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("cur_id", 32'(cur_id), 32'(m_id));
  endtask

  // Wait for the grant, then capture the frame mid-bit and measure its length in ticks
  task automatic run_frame(input logic [3:0] exp_ack, input logic [1:0] exp_id,
                           input logic [7:0] exp_byte, input bit keep_req);
    int          n;
    int          k;
    logic [11:0] cap;
    n   = 0;
    cap = '1;
    while (ack == 4'b0000 && n < 64) begin
      cycle();
      n++;
    end
    chk("frame_ack", 32'(ack), 32'(exp_ack));
    chk("frame_id", 32'(cur_id), 32'(exp_id));
    chk("frame_busy_rise", 32'(busy), 32'd1);
    chk("frame_start_level", 32'(tx), 32'd0);
    if (!keep_req) req = '0;
    n = 0;
    k = 0;
    while (busy && n < FRAME_TICKS * 4 + 64) begin
      cycle();
      n++;
      if (last_tick) begin
        k++;
        if (k % 16 == 8) cap[k/16] = tx;
      end
    end
    chk("frame_busy_fall", 32'(busy), 32'd0);
    chk("frame_ticks", 32'(k), 32'(FRAME_TICKS));
    chk("frame_start_bit", 32'(cap[0]), 32'd0);
    chk("frame_data_byte", 32'(cap[8:1]), 32'(exp_byte));
`ifdef UART_TX_PARITY_EN
    chk("frame_parity_bit", 32'(cap[9]), 32'(^exp_byte));
`endif
    chk("frame_stop_bit", 32'(cap[NBITS-1]), 32'd1);
    chk("frame_end_no_ack", 32'(ack), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_ack;
    logic [1:0]  exp_id;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int ack2_seen;
    checks   = 0;
    failures = 0;
    tick_div = 4;
    phase    = 0;
    rst      = 1'b1;
    req      = '0;
    data     = '0;
    tick16   = 1'b0;
    model_reset();

    vecs[0] = '{4'b0001, 32'h0000_00A5, 4'b0001, 2'd0, 8'hA5};
    vecs[1] = '{4'b0001, 32'h0000_003C, 4'b0001, 2'd0, 8'h3C};
    vecs[2] = '{4'b1001, 32'h4400_0081, 4'b1000, 2'd3, 8'h44};
    vecs[3] = '{4'b1100, 32'h5A7E_0000, 4'b0100, 2'd2, 8'h7E};
    vecs[4] = '{4'b0110, 32'h00C3_E100, 4'b0010, 2'd1, 8'hE1};
    vecs[5] = '{4'b1111, 32'h1122_3344, 4'b0100, 2'd2, 8'h22};
    vecs[6] = '{4'b1000, 32'hFF00_0000, 4'b1000, 2'd3, 8'hFF};

    // Reset values
    cycle();
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_id", 32'(cur_id), 32'd0);
    cycle();
    rst = 1'b0;

    // Idle line with ticks and no requests
    for (int i = 0; i < 64; i++) cycle();
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Directed vector table
    tick_div = 2;
    for (int i = 0; i < 7; i++) begin
      req  = vecs[i].req;
      data = vecs[i].data;
      run_frame(vecs[i].exp_ack, vecs[i].exp_id, vecs[i].exp_byte, 1'b0);
      cycle();
    end

    // Asynchronous reset in the middle of the data bits
    req  = 4'b0001;
    data = 32'h0000_000F;
    n = 0;
    while (ack == 4'b0000 && n < 64) begin
      cycle();
      n++;
    end
    chk("rst_mid_ack", 32'(ack), 32'b0001);
    req = '0;
    for (int i = 0; i < 100; i++) cycle();
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ack0", 32'(ack), 32'd0);
    chk("rst_mid_id", 32'(cur_id), 32'd0);
    model_reset();
    cycle();
    cycle();
    rst  = 1'b0;
    req  = 4'b0001;
    data = 32'h0000_005A;
    run_frame(4'b0001, 2'd0, 8'h5A, 1'b0);

    // All requesters held high: rotating grants from a reset pointer
    rst = 1'b1;
    cycle();
    rst  = 1'b0;
    req  = 4'b1111;
    data = 32'h4433_2211;
    for (int i = 0; i < 5; i++) begin
      run_frame(4'(1 << (i % 4)), 2'(i % 4), 8'(8'h11 * ((i % 4) + 1)), 1'b1);
    end
    req = '0;
    cycle();

    // Requester 2 withdraws before being granted and must never be acknowledged
    ack2_seen = 0;
    req = 4'b0110;
    n = 0;
    while (ack == 4'b0000 && n < 64) begin
      cycle();
      n++;
    end
    chk("drop_first_ack", 32'(ack), 32'b0010);
    req = 4'b0100;
    cycle();
    cycle();
    req = 4'b0000;
    for (int i = 0; i < 20; i++) cycle();
    req = 4'b1000;
    n = 0;
    while (ack == 4'b0000 && n < FRAME_TICKS * 4 + 64) begin
      cycle();
      n++;
      if (ack[2]) ack2_seen++;
    end
    chk("drop_next_ack", 32'(ack), 32'b1000);
    chk("drop_next_id", 32'(cur_id), 32'd3);
    chk("drop_never_acked", 32'(ack2_seen), 32'd0);
    req = '0;
    n = 0;
    while (busy && n < FRAME_TICKS * 4 + 64) begin
      cycle();
      n++;
    end
    chk("drop_frame_done", 32'(busy), 32'd0);

    // Randomized traffic, irregular and then dense ticks
    for (int pass = 0; pass < 2; pass++) begin
      tick_div = (pass == 0) ? 0 : 1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          req  = 4'($urandom_range(0, 15));
          data = $urandom;
        end
        cycle();
      end
    end
    req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin arbiter and frame sequencer that shares one UART transmit line between NUM_REQ byte requesters.
- Consumes the x16-oversample baud tick from the baud pulse generator and sequences start, data, optional parity and stop bits onto TX.
- Sits between the host-side byte sources and the UART pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- ID_W, clog2(NUM_REQ), width of the granted-requester index.

Ports:
- CLK  in  1  system clock; all logic on posedge CLK.
- RST  in  1  asynchronous, active-high reset.
- TICK16  in  1  one-cycle pulse at 16x baud, from the baud pulse generator.
- REQ  in  NUM_REQ  per-requester byte-valid; held high until ACK.
- DATA  in  8*NUM_REQ  flattened bytes; requester i occupies bits [8i+7:8i].
- ACK  out  NUM_REQ  one-cycle one-hot pulse: byte of requester i accepted.
- TX  out  1  serial line, idle high.
- BUSY  out  1  high from accept until the last stop bit completes.
- CUR_ID  out  ID_W  index of the requester being transmitted; holds last value when idle.

Behaviour:
- Reset (async, immediate): state=IDLE, TX=1, ACK=0, BUSY=0, CUR_ID=0, rr pointer=0, tick counter=0, bit index=0. Reset mid-frame aborts the frame; the line returns high at once; the byte is not retried.
- States: IDLE, START, DATA, PARITY (feature only), STOP.
- IDLE: if any REQ bit is high, grant the first set bit searching from rr pointer upward with wrap-around.
  - Next edge: ACK[grant]=1 for exactly one cycle, DATA slice latched into shift register, CUR_ID=grant, BUSY=1, TX=0, state=START, tick counter=0.
  - rr pointer becomes (grant+1) mod NUM_REQ.
  - No REQ set: stay in IDLE, TX=1.
- Bit timing: a 4-bit counter increments on each TICK16 outside IDLE. A bit ends on the TICK16 where counter==15; counter wraps to 0 and the FSM advances. Each bit therefore spans exactly 16 TICK16 pulses. A TICK16 coincident with the accept edge is ignored.
- START, at bit end: state=DATA, TX=byte[0].
- DATA: bits sent LSB first. After bit 7 ends, go to PARITY if enabled, else STOP; TX=1 in STOP.
- STOP: lasts STOP_BITS bit periods. After the last one ends, state=IDLE, BUSY=0. The earliest next accept is the following edge, so there is at least one idle cycle between frames.
- REQ handshake:
  - REQ changes during a frame are ignored.
  - A requester that drops REQ before it is granted is never ACKed.
  - A requester that keeps REQ high after ACK is treated as presenting a new byte.
- Simultaneous REQ: exactly one grant per frame; the other REQs wait. With all REQ high continuously, grants cycle 0,1,2,3,0…
- TICK16 while in IDLE is ignored.
- Frame length: (10 + parity + STOP_BITS - 1) × 16 TICK16 pulses.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state inserted after DATA; TX = even parity (XOR of the 8 data bits) for one bit period.
- Undefined: no PARITY state; frame is 8N1 or 8N2; no parity logic is compiled.

Decomposition:
- Shared package/include (uart_pkg): clog2 function, state encodings, TICKS_PER_BIT=16, DATA_BITS=8.
- Sub-module uart_rr_arbiter: combinational round-robin grant from REQ and rr pointer. Outputs a one-hot grant and its index. The scheduler registers both the grant and the pointer.

Test Plan:
- Reset, then idle: no REQ, TICK16 every 4 cycles → TX=1, BUSY=0, ACK=0 indefinitely.
- REQ=0001, DATA[7:0]=0xA5 → ACK=0001 for one cycle. TX sequence is 0,1,0,1,0,0,1,0,1,1, each level held for 16 TICK16. BUSY falls after 160 ticks.
- REQ=1111 held, distinct bytes 0x11/0x22/0x33/0x44 → CUR_ID and ACK order 0,1,2,3,0. No overlap between frames; at least one idle cycle between them.
- REQ=0100 dropped two cycles after REQ=0010 grant, before the frame ends → requester 2 never ACKed. Next grant goes only to a REQ bit still present.
- RST asserted mid-DATA of byte 0x0F → TX=1, BUSY=0, state IDLE in the same cycle. After release, a fresh REQ transmits a full frame.
- With UART_TX_PARITY_EN, byte 0x07 → parity bit 1, frame 11×16 ticks; with STOP_BITS=2, frame 12×16 ticks.
